// File: rtl/booth_mult_seq.sv
// Radix-2 Booth sequential multiplier. Handles signed and unsigned operands
// by extending them to WIDTH+1 bits and feeding them into one signed datapath.
module booth_mult_seq #(
  parameter int WIDTH = 24,
  parameter int CNTW  = $clog2(WIDTH + 2)
) (
  input  logic                 CLK,
  input  logic                 RSTK,
  input  logic [WIDTH-1:0]     m1,
  input  logic [WIDTH-1:0]     m2,
  input  logic                 BSIGNED,
  input  logic                 BREQ,
  input  logic                 BABORT,
  output logic                 BRDY,
  output logic                 BACK,
  output logic [2*WIDTH-1:0]   res
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_next;
  logic [WIDTH:0]    a, m, q;
  logic              q1;
  logic [CNTW-1:0]   count;

  logic [WIDTH:0]    a_sum, a_sh, q_sh;
  logic              last_iter;

  assign last_iter = (count == CNTW'(WIDTH));

  always_comb begin
    a_sum = a;
    case ({q[0], q1})
      2'b01:   a_sum = a + m;
      2'b10:   a_sum = a - m;
      default: a_sum = a;
    endcase
    // Arithmetic shift of {A,Q,Q1}: the new A's sign bit is replicated
    a_sh = {a_sum[WIDTH], a_sum[WIDTH:1]};
    q_sh = {a_sum[0], q[WIDTH:1]};
  end

  always_ff @(posedge CLK or posedge RSTK) begin
    if (RSTK) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (BREQ) state_next = CALC;
      CALC: begin
        if (BABORT)         state_next = IDLE;
        else if (last_iter) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    BRDY = (state == IDLE);
    BACK = (state == DONE);
  end

  always_ff @(posedge CLK or posedge RSTK) begin
    if (RSTK) begin
      a     <= '0;
      m     <= '0;
      q     <= '0;
      q1    <= 1'b0;
      count <= '0;
      res   <= '0;
    end else if (state == IDLE && BREQ) begin
      a     <= '0;
      m     <= {BSIGNED & m1[WIDTH-1], m1};
      q     <= {BSIGNED & m2[WIDTH-1], m2};
      q1    <= 1'b0;
      count <= '0;
    end else if (state == CALC && !BABORT) begin
      a     <= a_sh;
      q     <= q_sh;
      q1    <= q[0];
      count <= count + CNTW'(1);
      // The top two bits of the 2W+2-bit product are pure sign extension
      if (last_iter) res <= {a_sh[WIDTH-2:0], q_sh};
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq at WIDTH=8 and WIDTH=24, using
// directed and random operands checked against a plain-arithmetic model.
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [7:0]  x8 = '0, y8 = '0;
  logic        sg8 = 1'b0, req8 = 1'b0, abort8 = 1'b0;
  logic        rdy8, back8;
  logic [15:0] res8;

  logic [23:0] x24 = '0, y24 = '0;
  logic        sg24 = 1'b0, req24 = 1'b0, abort24 = 1'b0;
  logic        rdy24, back24;
  logic [47:0] res24;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(8)) u8 (
    .CLK(clk), .RSTK(rst), .m1(x8), .m2(y8), .BSIGNED(sg8), .BREQ(req8),
    .BABORT(abort8), .BRDY(rdy8), .BACK(back8), .res(res8)
  );

  booth_mult_seq #(.WIDTH(24)) u24 (
    .CLK(clk), .RSTK(rst), .m1(x24), .m2(y24), .BSIGNED(sg24), .BREQ(req24),
    .BABORT(abort24), .BRDY(rdy24), .BACK(back24), .res(res24)
  );

  function automatic logic [15:0] model8(logic [7:0] a, logic [7:0] b, logic s);
    longint pa, pb, p;
    pa = s ? {{56{a[7]}}, a} : {56'b0, a};
    pb = s ? {{56{b[7]}}, b} : {56'b0, b};
    p  = pa * pb;
    return p[15:0];
  endfunction

  function automatic logic [47:0] model24(logic [23:0] a, logic [23:0] b, logic s);
    longint pa, pb, p;
    pa = s ? {{40{a[23]}}, a} : {40'b0, a};
    pb = s ? {{40{b[23]}}, b} : {40'b0, b};
    p  = pa * pb;
    return p[47:0];
  endfunction

  // Latency is the number of negedges after the accept edge until BACK is seen
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      output int lat, output logic busy_ok, output logic [15:0] r);
    lat = -1;
    busy_ok = 1'b1;
    for (int i = 0; i < 50 && !rdy8; i++) @(negedge clk);
    x8 = a; y8 = b; sg8 = s; req8 = 1'b1;
    @(negedge clk);
    req8 = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (back8) begin lat = n; break; end
      if (rdy8) busy_ok = 1'b0;
      @(negedge clk);
    end
    r = res8;
  endtask

  task automatic run24(input logic [23:0] a, input logic [23:0] b, input logic s,
                       output int lat, output logic busy_ok, output logic [47:0] r);
    lat = -1;
    busy_ok = 1'b1;
    for (int i = 0; i < 80 && !rdy24; i++) @(negedge clk);
    x24 = a; y24 = b; sg24 = s; req24 = 1'b1;
    @(negedge clk);
    req24 = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      if (back24) begin lat = n; break; end
      if (rdy24) busy_ok = 1'b0;
      @(negedge clk);
    end
    r = res24;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3;
    n_total++; if (rdy8 !== 1'b1) $display("[TB] FAIL reset_rdy8 got %b want 1", rdy8); else n_pass++;
    n_total++; if (back8 !== 1'b0) $display("[TB] FAIL reset_back8 got %b want 0", back8); else n_pass++;
    n_total++; if (res8 !== 16'h0) $display("[TB] FAIL reset_res8 got %h want 0", res8); else n_pass++;
    n_total++; if (rdy24 !== 1'b1) $display("[TB] FAIL reset_rdy24 got %b want 1", rdy24); else n_pass++;
    n_total++; if (back24 !== 1'b0) $display("[TB] FAIL reset_back24 got %b want 0", back24); else n_pass++;
    n_total++; if (res24 !== 48'h0) $display("[TB] FAIL reset_res24 got %h want 0", res24); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [7:0]  va [5] = '{8'h80, 8'hFF, 8'hFF, 8'hFD, 8'hFD};
    logic [7:0]  vb [5] = '{8'h80, 8'hFF, 8'hFF, 8'h05, 8'h05};
    logic        vs [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] ve [5] = '{16'h4000, 16'hFE01, 16'h0001, 16'hFFF1, 16'h04F1};
    int lat; logic busy_ok; logic [15:0] r;
    for (int i = 0; i < 5; i++) begin
      run8(va[i], vb[i], vs[i], lat, busy_ok, r);
      n_total++; if (r !== ve[i]) $display("[TB] FAIL directed%0d_res got %h want %h", i, r, ve[i]); else n_pass++;
      n_total++; if (lat !== 10) $display("[TB] FAIL directed%0d_latency got %0d want 10", i, lat); else n_pass++;
      n_total++; if (!busy_ok) $display("[TB] FAIL directed%0d_busy got rdy high want low", i); else n_pass++;
      @(negedge clk);
      n_total++; if (back8 !== 1'b0 || rdy8 !== 1'b1)
        $display("[TB] FAIL directed%0d_after got back=%b rdy=%b want 0/1", i, back8, rdy8); else n_pass++;
    end
  endtask

  task automatic test_w24_max;
    int lat; logic busy_ok; logic [47:0] r;
    run24(24'hFFFFFF, 24'hFFFFFF, 1'b0, lat, busy_ok, r);
    n_total++; if (r !== 48'hFFFFFE000001) $display("[TB] FAIL w24_max_res got %h want fffffe000001", r); else n_pass++;
    n_total++; if (lat !== 26) $display("[TB] FAIL w24_latency got %0d want 26", lat); else n_pass++;
    n_total++; if (!busy_ok) $display("[TB] FAIL w24_busy got rdy high want low"); else n_pass++;
    @(negedge clk);
    n_total++; if (back24 !== 1'b0 || rdy24 !== 1'b1)
      $display("[TB] FAIL w24_after got back=%b rdy=%b want 0/1", back24, rdy24); else n_pass++;
  endtask

  task automatic test_random;
    int lat; logic busy_ok;
    logic [15:0] r8, e8; logic [47:0] r24, e24;
    logic [7:0] a8, b8; logic [23:0] a24, b24; logic s;
    for (int i = 0; i < 40; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); s = 1'($urandom);
      e8 = model8(a8, b8, s);
      run8(a8, b8, s, lat, busy_ok, r8);
      n_total++; if (r8 !== e8 || lat !== 10)
        $display("[TB] FAIL rand8 %h*%h s=%b got %h lat %0d want %h lat 10", a8, b8, s, r8, lat, e8); else n_pass++;
    end
    for (int i = 0; i < 12; i++) begin
      a24 = 24'($urandom); b24 = 24'($urandom); s = 1'($urandom);
      if (i == 0) begin a24 = 24'h800000; b24 = 24'h800000; s = 1'b1; end
      e24 = model24(a24, b24, s);
      run24(a24, b24, s, lat, busy_ok, r24);
      n_total++; if (r24 !== e24 || lat !== 26)
        $display("[TB] FAIL rand24 %h*%h s=%b got %h lat %0d want %h lat 26", a24, b24, s, r24, lat, e24); else n_pass++;
    end
  endtask

  task automatic test_abort;
    int lat; logic busy_ok; logic [15:0] prior; int backs;
    // stop_at=4 aborts on the 4th CALC edge, stop_at=9 on the final iteration edge
    int stop_at [2] = '{4, 9};
    run8(8'h12, 8'h34, 1'b0, lat, busy_ok, prior);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      for (int i = 0; i < 50 && !rdy8; i++) @(negedge clk);
      x8 = 8'h55; y8 = 8'h66; sg8 = 1'b0; req8 = 1'b1;
      @(negedge clk);
      req8 = 1'b0;
      repeat (stop_at[k] - 1) @(negedge clk);
      abort8 = 1'b1;
      @(negedge clk);
      abort8 = 1'b0;
      n_total++; if (rdy8 !== 1'b1 || back8 !== 1'b0)
        $display("[TB] FAIL abort%0d_idle got rdy=%b back=%b want 1/0", k, rdy8, back8); else n_pass++;
      backs = 0;
      for (int i = 0; i < 15; i++) begin
        if (back8) backs++;
        @(negedge clk);
      end
      n_total++; if (backs !== 0) $display("[TB] FAIL abort%0d_back got %0d pulses want 0", k, backs); else n_pass++;
      n_total++; if (res8 !== model8(8'h12, 8'h34, 1'b0))
        $display("[TB] FAIL abort%0d_res got %h want %h", k, res8, model8(8'h12, 8'h34, 1'b0)); else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    int n1, n2; logic [15:0] r1, r2;
    n1 = -1; n2 = -1; r1 = '0; r2 = '0;
    for (int i = 0; i < 50 && !rdy8; i++) @(negedge clk);
    x8 = 8'h0F; y8 = 8'h11; sg8 = 1'b0; req8 = 1'b1;
    @(negedge clk);
    for (int n = 1; n <= 60; n++) begin
      // Operands changed while busy must only affect the second accept
      if (n == 2) x8 = 8'hF0;
      if (back8) begin
        if (n1 < 0) begin n1 = n; r1 = res8; end
        else begin n2 = n; r2 = res8; req8 = 1'b0; break; end
      end
      @(negedge clk);
    end
    req8 = 1'b0;
    n_total++; if (n1 !== 10) $display("[TB] FAIL b2b_first_latency got %0d want 10", n1); else n_pass++;
    n_total++; if (n2 - n1 !== 11) $display("[TB] FAIL b2b_period got %0d want 11", n2 - n1); else n_pass++;
    n_total++; if (r1 !== model8(8'h0F, 8'h11, 1'b0)) $display("[TB] FAIL b2b_res1 got %h want %h", r1, model8(8'h0F, 8'h11, 1'b0)); else n_pass++;
    n_total++; if (r2 !== model8(8'hF0, 8'h11, 1'b0)) $display("[TB] FAIL b2b_res2 got %h want %h", r2, model8(8'hF0, 8'h11, 1'b0)); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    n_total++; if (rdy8 !== 1'b1) $display("[TB] FAIL b2b_idle got rdy=%b want 1", rdy8); else n_pass++;
  endtask

  task automatic test_async_reset;
    int lat; logic busy_ok; logic [15:0] r; int backs;
    for (int i = 0; i < 50 && !rdy8; i++) @(negedge clk);
    x8 = 8'hAB; y8 = 8'hCD; sg8 = 1'b1; req8 = 1'b1;
    @(negedge clk);
    req8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_total++; if (rdy8 !== 1'b1 || back8 !== 1'b0)
      $display("[TB] FAIL async_rst_flags got rdy=%b back=%b want 1/0", rdy8, back8); else n_pass++;
    n_total++; if (res8 !== 16'h0 || res24 !== 48'h0)
      $display("[TB] FAIL async_rst_res got %h/%h want 0/0", res8, res24); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    backs = 0;
    for (int i = 0; i < 12; i++) begin
      if (back8) backs++;
      @(negedge clk);
    end
    n_total++; if (backs !== 0) $display("[TB] FAIL async_rst_back got %0d pulses want 0", backs); else n_pass++;
    run8(8'h03, 8'h07, 1'b0, lat, busy_ok, r);
    n_total++; if (r !== 16'h0015 || lat !== 10)
      $display("[TB] FAIL async_rst_after got %h lat %0d want 0015 lat 10", r, lat); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_w24_max();
    test_random();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/booth_mult_seq.md
# booth_mult_seq

Parametrised radix-2 Booth sequential multiplier with an internal adder/subtractor, per-operation signed/unsigned mode, a ready/request/acknowledge handshake, and synchronous abort. It is the successor to the fixed 24-bit mantissa multiplier. The FPU multiply path instantiates it with WIDTH=24 for single-precision mantissas. It also serves narrower integer multiply requests.

## Interface
- WIDTH, 24, operand width in bits (≥2)
- CNTW, $clog2(WIDTH+2), iteration counter width
- CLK  in  1  clock, all state on rising edge
- RSTK  in  1  reset; asynchronous, active-high
- m1  in  WIDTH  multiplicand, sampled on accept
- m2  in  WIDTH  multiplier, sampled on accept
- BSIGNED  in  1  1 = two's-complement operands, 0 = unsigned; sampled on accept
- BREQ  in  1  start request
- BABORT  in  1  synchronous abort of an in-flight operation
- BRDY  out  1  idle, able to accept
- BACK  out  1  one-cycle result-valid pulse
- res  out  2*WIDTH  product; held from BACK until the next BACK

## Operation
- Internal state:
  - A, M: WIDTH+1 bits.
  - Q: WIDTH+1 bits.
  - Q1: 1 bit.
  - count: CNTW bits.
  - FSM: IDLE, CALC, DONE.
- Operand extension to WIDTH+1 bits: sign-extended if BSIGNED=1, zero-extended if BSIGNED=0. This lets one signed Booth datapath cover both modes.
- IDLE:
  - BRDY=1.
  - On BREQ=1 at an edge: A←0, M←ext(m1), Q←ext(m2), Q1←0, count←0, go to CALC.
  - BABORT is ignored in IDLE.
- CALC, one iteration per edge, based on {Q[0],Q1}:
  - 01: A←A+M.
  - 10: A←A−M (two's complement, WIDTH+1 bits, carry-out discarded).
  - 00 or 11: no add.
  - Then arithmetic shift right of {A,Q,Q1} by 1, with the sign bit of the new A replicated.
  - count←count+1.
- After iteration index count=WIDTH (WIDTH+1 iterations total):
  - res←low 2*WIDTH bits of {A,Q} (post-shift).
  - Go to DONE.
- DONE: BACK=1 for exactly this cycle; next edge returns to IDLE.
- Priority in CALC: BABORT=1 at an edge forces IDLE.
  - That edge performs no iteration.
  - res keeps its previous value; no BACK is issued.
  - Abort takes priority even on the final-iteration edge.
- BABORT in DONE is ignored; BACK still pulses.
- BREQ while BRDY=0 is ignored, not queued. The requester must hold BREQ until it sees BRDY=1 at an edge.
- Full-range products fit with no overflow:
  - Signed −2^(W−1)·−2^(W−1) = 2^(2W−2).
  - Unsigned max (2^W−1)^2.

## Timing
- Reset (asynchronous, immediate):
  - FSM=IDLE; A, M, Q, Q1, count, res = 0.
  - BRDY=1, BACK=0.
  - Reset mid-CALC discards the operation with no BACK.
- BRDY and BACK are decoded from FSM state only, never from inputs.
- Accept at edge 0. Iterations at edges 1..WIDTH+1. res is updated at edge WIDTH+1.
- BACK is high during the cycle between edges WIDTH+1 and WIDTH+2.
- BRDY rises after edge WIDTH+2.
- Back-to-back throughput: one operation per WIDTH+3 cycles.
- A BREQ sampled at edge WIDTH+2 is not accepted; the earliest next accept is edge WIDTH+3.
- res changes only at the final-iteration edge and at reset. It is stable during and after BACK.

## Test plan
- WIDTH=8, BSIGNED=1, m1=0x80, m2=0x80 -> BACK exactly 10 cycles after the accept edge, res=0x4000.
- WIDTH=8, BSIGNED=0, m1=0xFF, m2=0xFF -> res=0xFE01. Same operands with BSIGNED=1 -> res=0x0001.
- WIDTH=8, BSIGNED=1, m1=0xFD (−3), m2=0x05 -> res=0xFFF1. BSIGNED=0, m1=0xFD, m2=0x05 -> res=0x04F1.
- WIDTH=24, BSIGNED=0, m1=m2=0xFFFFFF -> res=0xFFFFFE000001, BACK exactly one cycle, BRDY low from the accept edge through DONE.
- BABORT at the 4th CALC edge -> IDLE next cycle, BACK never asserted, res holds the prior product. BREQ held high throughout busy -> exactly one accept, on the first edge with BRDY=1.
- RSTK asserted asynchronously mid-CALC (between edges) -> outputs zero immediately, BRDY=1. After deassert, a new operation 0x03·0x07 (WIDTH=8, unsigned) -> res=0x0015.
